// File: rtl/div_ctrl_if.sv
// EX-stage <-> divide sequencer handshake: operands, start/annul request, registered result/ready.
interface div_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU; one quotient bit per clock,
// result {remainder, quotient} held with ready until EX drops start.
module div_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic         clk,
    input  logic         rst,
    div_ctrl_if.slave    bus
);
    localparam int unsigned DVD_W = 2 * DATA_W + 1;
    localparam int unsigned RES_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DVD_W-1:0]    dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                signed_q, signed_d;
    logic                op1_sign_q, op1_sign_d;
    logic                op2_sign_q, op2_sign_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Operand magnitudes for a signed divide; unsigned operands pass through.
    assign abs1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ?
                  (DATA_W'(0) - bus.opdata1_i) : bus.opdata1_i;
    assign abs2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ?
                  (DATA_W'(0) - bus.opdata2_i) : bus.opdata2_i;

    assign diff = dividend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

    // Quotient takes the XOR of operand signs, remainder takes the dividend sign.
    assign quo_fix = (signed_q && (op1_sign_q ^ op2_sign_q)) ?
                     (DATA_W'(0) - dividend_q[DATA_W-1:0]) : dividend_q[DATA_W-1:0];
    assign rem_fix = (signed_q && op1_sign_q) ?
                     (DATA_W'(0) - dividend_q[2*DATA_W:DATA_W+1]) : dividend_q[2*DATA_W:DATA_W+1];

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        op1_sign_d = op1_sign_q;
        op2_sign_d = op2_sign_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == DATA_W'(0)) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        dividend_d = {DATA_W'(0), abs1, 1'b0};
                        divisor_d  = abs2;
                        signed_d   = bus.signed_div_i;
                        op1_sign_d = bus.opdata1_i[DATA_W-1];
                        op2_sign_d = bus.opdata2_i[DATA_W-1];
                    end
                end
            end

            DivByZero: begin
                state_d    = DivEnd;
                dividend_d = '0;
            end

            DivOn: begin
                if (bus.annul_i) begin
                    state_d  = DivFree;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    dividend_d = diff[DATA_W] ? (dividend_q << 1)
                                              : {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    // Result is published on the same edge the fixup lands.
                    state_d    = DivEnd;
                    dividend_d = {rem_fix, dividend_q[DATA_W], quo_fix};
                    result_d   = {rem_fix, quo_fix};
                    ready_d    = 1'b1;
                    cnt_d      = '0;
                end
            end

            DivEnd: begin
                if (bus.start_i) begin
                    result_d = {dividend_q[2*DATA_W:DATA_W+1], dividend_q[DATA_W-1:0]};
                    ready_d  = 1'b1;
                end else begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = DivFree;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            dividend_q <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            op1_sign_q <= 1'b0;
            op2_sign_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            op1_sign_q <= op1_sign_d;
            op2_sign_q <= op2_sign_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed and random DIV/DIVU requests against an arithmetic reference model.
module tb_div_ctrl;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_ctrl_if #(.DATA_W(W)) bus ();

    div_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division, remainder takes the dividend's sign, x/0 gives zero.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (b == 32'd0) ? 2 : W + 1;
    endfunction

    // Issue a request and count edges (first edge = 0) until ready; -1 on timeout.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        lat = -1;
        res = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (bus.ready_o === 1'b1) begin
                lat = k;
                res = bus.result_o;
                break;
            end
        end
    endtask

    task automatic end_op();
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0; bus.opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b exp 0", bus.ready_o); end
        n_cmp++;
        if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h exp 0", bus.result_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, lat, res);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL divu_lat: got %0d exp 33", lat); end
        n_cmp++;
        if (res !== {32'h2, 32'hE}) begin n_err++; $display("FAIL divu_res: got %h exp %h", res, {32'h2, 32'hE}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== {32'h2, 32'hE}) begin
            n_err++; $display("FAIL divu_hold: got rdy=%b res=%h exp rdy=1 res=%h", bus.ready_o, bus.result_o, {32'h2, 32'hE});
        end
        end_op();
        n_cmp++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            n_err++; $display("FAIL divu_release: got rdy=%b res=%h exp rdy=0 res=0", bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'h2, lat, res);
        n_cmp++;
        if (res !== model(1'b1, 32'hFFFFFFF9, 32'h2) || lat !== 33) begin
            n_err++; $display("FAIL div_neg7_2: got %h lat %0d exp %h lat 33", res, lat, model(1'b1, 32'hFFFFFFF9, 32'h2));
        end
        end_op();
        do_div(1'b1, 32'h7, 32'hFFFFFFFE, lat, res);
        n_cmp++;
        if (res !== model(1'b1, 32'h7, 32'hFFFFFFFE) || lat !== 33) begin
            n_err++; $display("FAIL div_7_neg2: got %h lat %0d exp %h lat 33", res, lat, model(1'b1, 32'h7, 32'hFFFFFFFE));
        end
        end_op();
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] res;
        for (int s = 0; s < 2; s++) begin
            do_div(s[0], 32'h12345678, 32'h0, lat, res);
            n_cmp++;
            if (lat !== 2 || res !== 64'd0) begin
                n_err++; $display("FAIL div_zero s=%0d: got lat %0d res %h exp lat 2 res 0", s, lat, res);
            end
            end_op();
        end
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; bit seen;
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'hFFFFFFFF; bus.opdata2_i = 32'd3;
        bus.annul_i = 1'b0; bus.start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = bus.ready_o;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL annul_no_ready: got ready seen=%b exp 0", seen); end
        do_div(1'b0, 32'd9, 32'd3, lat, res);
        n_cmp++;
        if (lat !== 33 || res !== {32'd0, 32'd3}) begin
            n_err++; $display("FAIL annul_next: got lat %0d res %h exp lat 33 res %h", lat, res, {32'd0, 32'd3});
        end
        end_op();
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res;
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd13;
        bus.annul_i = 1'b0; bus.start_i = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            n_err++; $display("FAIL reset_mid: got rdy=%b res=%h exp rdy=0 res=0", bus.ready_o, bus.result_o);
        end
        rst = 1'b0;
        do_div(1'b0, 32'd1000, 32'd13, lat, res);
        n_cmp++;
        if (lat !== 33 || res !== model(1'b0, 32'd1000, 32'd13)) begin
            n_err++; $display("FAIL reset_restart: got lat %0d res %h exp lat 33 res %h", lat, res, model(1'b0, 32'd1000, 32'd13));
        end
        end_op();
    endtask

    task automatic test_edges();
        int lat; logic [63:0] res;
        logic [31:0] ea [3];
        logic [31:0] eb [3];
        logic        es [3];
        ea = '{32'h80000000, 32'hFFFFFFFF, 32'd5};
        eb = '{32'hFFFFFFFF, 32'd1, 32'd9};
        es = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_div(es[i], ea[i], eb[i], lat, res);
            n_cmp++;
            if (lat !== 33 || res !== model(es[i], ea[i], eb[i])) begin
                n_err++; $display("FAIL edge_%0d: got lat %0d res %h exp lat 33 res %h", i, lat, res, model(es[i], ea[i], eb[i]));
            end
            end_op();
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] res;
        logic s; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                default: b = $urandom;
            endcase
            do_div(s, a, b, lat, res);
            n_cmp++;
            if (lat !== exp_lat(b) || res !== model(s, a, b)) begin
                n_err++;
                $display("FAIL random_%0d s=%b a=%h b=%h: got lat %0d res %h exp lat %0d res %h",
                         i, s, a, b, lat, res, exp_lat(b), model(s, a, b));
            end
            end_op();
            n_cmp++;
            if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL random_release_%0d: got %b exp 0", i, bus.ready_o); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
